svt_link_receiver: RTL and testbench

SVT_LINK_RECEIVER -- requirements
Module: svt_link_receiver

---
 rtl/svt_link_pkg.sv | 13 +
 rtl/svt_rx_fifo_mem.sv | 53 +++++
 rtl/svt_link_receiver.sv | 113 +++++++++++
 tb/tb_svt_link_receiver.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svt_link_pkg.sv
// Shared definitions for the SVT link receiver: default word width,
// event counter width and the stored word layout.
package svt_link_pkg;

  localparam int SVT_DATA_W = 21;
  localparam int SVT_EVT_W  = 16;

  typedef struct packed {
    logic [SVT_DATA_W-1:0] data;
    logic                  ee;
  } svt_word_t;

endpackage

// File: rtl/svt_rx_fifo_mem.sv
// Storage array, wrapping pointers and occupancy for the receiver FIFO.
// First-word-fall-through: the head word is read asynchronously.
module svt_rx_fifo_mem #(
  parameter int W     = 22,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  output logic [W-1:0]  o_rd_data,
  output logic [AW:0]   o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // The array itself carries no reset; stale contents are never visible
  // because the caller qualifies the head word with occupancy.
  always_ff @(posedge clk) begin
    if (rst_n && i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_wr_en, i_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/svt_link_receiver.sv
// SVT link receiver: registered input stage, FWFT FIFO, HOLD backpressure,
// sticky overflow, end-event counter. Parity check enabled by SVT_RX_PARITY_EN.
module svt_link_receiver
  import svt_link_pkg::*;
#(
  parameter int DATA_W      = SVT_DATA_W,
  parameter int DEPTH       = 16,
  parameter int HOLD_MARGIN = 4
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  input  logic                 IN_DS,
  input  logic [DATA_W-1:0]    IN_DATA,
  input  logic                 IN_EE,
`ifdef SVT_RX_PARITY_EN
  input  logic                 IN_PAR,
`endif
  output logic                 HOLD,
  output logic [DATA_W-1:0]    OUT_DATA,
  output logic                 OUT_EE,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 OVERFLOW,
  output logic [SVT_EVT_W-1:0] EVT_CNT,
  output logic                 PAR_ERR
);

  localparam int AW         = $clog2(DEPTH);
  localparam int CNT_W      = AW + 1;
  localparam int HOLD_LEVEL = DEPTH - HOLD_MARGIN;

  logic                 r_in_ds;
  logic [DATA_W-1:0]    r_in_data;
  logic                 r_in_ee;
  logic                 r_hold;
  logic                 r_overflow;
  logic [SVT_EVT_W-1:0] r_evt_cnt;

  logic [CNT_W-1:0]     w_count;
  logic [DATA_W:0]      w_rd_word;
  logic                 w_valid;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  assign w_valid = (w_count != '0);
  assign w_full  = (w_count == CNT_W'(DEPTH));
  assign w_pop   = w_valid & OUT_READY;
  // A staged word still fits into a full FIFO when the head leaves on the same edge.
  assign w_push  = r_in_ds & (~w_full | w_pop);
  assign w_drop  = r_in_ds & w_full & ~w_pop;

  svt_rx_fifo_mem #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (CLOCK),
    .rst_n     (RESET_N),
    .i_wr_en   (w_push),
    .i_wr_data ({r_in_data, r_in_ee}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_word),
    .o_count   (w_count)
  );

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_in_ds    <= 1'b0;
      r_in_data  <= '0;
      r_in_ee    <= 1'b0;
      r_hold     <= 1'b0;
      r_overflow <= 1'b0;
      r_evt_cnt  <= '0;
    end else begin
      r_in_ds   <= IN_DS;
      r_in_data <= IN_DATA;
      r_in_ee   <= IN_EE;
      r_hold    <= (w_count >= CNT_W'(HOLD_LEVEL));
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_push && r_in_ee) begin
        r_evt_cnt <= r_evt_cnt + 1'b1;
      end
    end
  end

`ifdef SVT_RX_PARITY_EN
  logic r_par_err;

  // Even parity: data, EE and parity bit together must XOR to zero.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_par_err <= 1'b0;
    end else if (IN_DS && (^{IN_DATA, IN_EE, IN_PAR})) begin
      r_par_err <= 1'b1;
    end
  end

  assign PAR_ERR = r_par_err;
`else
  assign PAR_ERR = 1'b0;
`endif

  assign HOLD      = r_hold;
  assign OUT_VALID = w_valid;
  assign OUT_DATA  = w_valid ? w_rd_word[DATA_W:1] : '0;
  assign OUT_EE    = w_valid & w_rd_word[0];
  assign OVERFLOW  = r_overflow;
  assign EVT_CNT   = r_evt_cnt;

endmodule

// File: tb/tb_svt_link_receiver.sv
// Self-checking bench for svt_link_receiver: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_svt_link_receiver;
  import svt_link_pkg::*;

  localparam int DW     = 21;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;

  logic          CLOCK;
  logic          RESET_N;
  logic          IN_DS;
  logic [DW-1:0] IN_DATA;
  logic          IN_EE;
`ifdef SVT_RX_PARITY_EN
  logic          IN_PAR;
`endif
  logic          HOLD;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_EE;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic          OVERFLOW;
  logic [15:0]   EVT_CNT;
  logic          PAR_ERR;

  int errors = 0;
  int checks = 0;

  // Reference model state
  svt_word_t   m_q[$];
  svt_word_t   m_st;
  bit          m_st_v;
  bit          m_hold;
  bit          m_ovf;
  bit          m_par;
  logic [15:0] m_evt;

  typedef struct {
    bit          rstn;
    bit          ds;
    logic [20:0] data;
    bit          ee;
    bit          ready;
    bit          e_valid;
    logic [20:0] e_data;
    bit          e_ee;
    bit          e_hold;
    bit          e_ovf;
    logic [15:0] e_evt;
  } vec_t;

  vec_t tbl[9];

  svt_link_receiver #(
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .HOLD_MARGIN (MARGIN)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .IN_DS     (IN_DS),
    .IN_DATA   (IN_DATA),
    .IN_EE     (IN_EE),
`ifdef SVT_RX_PARITY_EN
    .IN_PAR    (IN_PAR),
`endif
    .HOLD      (HOLD),
    .OUT_DATA  (OUT_DATA),
    .OUT_EE    (OUT_EE),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OVERFLOW  (OVERFLOW),
    .EVT_CNT   (EVT_CNT),
    .PAR_ERR   (PAR_ERR)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the rising edge,
  // return at the falling edge where outputs are sampled.
  task automatic step(input bit rstn, input bit ds, input logic [20:0] data,
                      input bit ee, input bit ready, input bit par);
    int occ;
    bit pop;
    RESET_N   = rstn;
    IN_DS     = ds;
    IN_DATA   = data;
    IN_EE     = ee;
    OUT_READY = ready;
`ifdef SVT_RX_PARITY_EN
    IN_PAR    = par;
`endif
    @(posedge CLOCK);
    if (!rstn) begin
      m_q.delete();
      m_st_v = 1'b0;
      m_hold = 1'b0;
      m_ovf  = 1'b0;
      m_par  = 1'b0;
      m_evt  = '0;
    end else begin
      occ    = m_q.size();
      pop    = (occ > 0) && ready;
      m_hold = (occ >= DEPTH - MARGIN);
      if (pop) void'(m_q.pop_front());
      if (m_st_v) begin
        if (occ < DEPTH || pop) begin
          m_q.push_back(m_st);
          if (m_st.ee) m_evt = m_evt + 16'd1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (ds && ((^data) ^ ee ^ par)) m_par = 1'b1;
      m_st_v  = ds;
      m_st.data = data;
      m_st.ee   = ee;
    end
    @(negedge CLOCK);
  endtask

  task automatic check_model(input string tag);
    bit ev;
    bit ep;
    ev = (m_q.size() != 0);
`ifdef SVT_RX_PARITY_EN
    ep = m_par;
`else
    ep = 1'b0;
`endif
    chk({tag, " valid"}, OUT_VALID, ev);
    chk({tag, " data"}, OUT_DATA, ev ? m_q[0].data : 21'd0);
    chk({tag, " ee"}, OUT_EE, ev ? m_q[0].ee : 1'b0);
    chk({tag, " hold"}, HOLD, m_hold);
    chk({tag, " overflow"}, OVERFLOW, m_ovf);
    chk({tag, " evt_cnt"}, EVT_CNT, m_evt);
    chk({tag, " par_err"}, PAR_ERR, ep);
  endtask

  task automatic idle(input bit ready);
    step(1'b1, 1'b0, 21'd0, 1'b0, ready, 1'b0);
  endtask

  task automatic push(input logic [20:0] data, input bit ee, input bit ready);
    step(1'b1, 1'b1, data, ee, ready, (^data) ^ ee);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 21'd0, 1'b0, 1'b0, 1'b0);
    check_model("reset");
  endtask

  initial begin
    RESET_N = 1'b0; IN_DS = 1'b0; IN_DATA = '0; IN_EE = 1'b0; OUT_READY = 1'b0;
`ifdef SVT_RX_PARITY_EN
    IN_PAR = 1'b0;
`endif

    // rstn ds data ee ready | valid data ee hold ovf evt
    tbl[0] = '{0, 1, 21'h12345, 1, 1, 0, 21'h00000, 0, 0, 0, 16'd0};
    tbl[1] = '{1, 1, 21'h1ABCD, 1, 0, 0, 21'h00000, 0, 0, 0, 16'd0};
    tbl[2] = '{1, 0, 21'h00000, 0, 0, 1, 21'h1ABCD, 1, 0, 0, 16'd1};
    tbl[3] = '{1, 1, 21'h00055, 0, 1, 0, 21'h00000, 0, 0, 0, 16'd1};
    tbl[4] = '{1, 0, 21'h00000, 0, 0, 1, 21'h00055, 0, 0, 0, 16'd1};
    tbl[5] = '{1, 0, 21'h00000, 0, 1, 0, 21'h00000, 0, 0, 0, 16'd1};
    tbl[6] = '{1, 0, 21'h00000, 0, 1, 0, 21'h00000, 0, 0, 0, 16'd1};
    tbl[7] = '{1, 1, 21'h0AAAA, 1, 1, 0, 21'h00000, 0, 0, 0, 16'd1};
    tbl[8] = '{1, 0, 21'h00000, 0, 0, 1, 21'h0AAAA, 1, 0, 0, 16'd2};

    step(1'b0, 1'b0, 21'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rstn, tbl[i].ds, tbl[i].data, tbl[i].ee, tbl[i].ready,
           (^tbl[i].data) ^ tbl[i].ee);
      chk($sformatf("vec%0d valid", i), OUT_VALID, tbl[i].e_valid);
      chk($sformatf("vec%0d data", i), OUT_DATA, tbl[i].e_data);
      chk($sformatf("vec%0d ee", i), OUT_EE, tbl[i].e_ee);
      chk($sformatf("vec%0d hold", i), HOLD, tbl[i].e_hold);
      chk($sformatf("vec%0d overflow", i), OVERFLOW, tbl[i].e_ovf);
      chk($sformatf("vec%0d evt_cnt", i), EVT_CNT, tbl[i].e_evt);
    end

    // Backpressure: 12 strobes, HOLD follows occupancy 12 by one cycle
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      push(21'(k), 1'b0, 1'b0);
      chk("bp hold early", HOLD, 1'b0);
      check_model("bp fill");
    end
    idle(1'b0);
    chk("bp hold at occ12", HOLD, 1'b0);
    check_model("bp occ12");
    idle(1'b0);
    chk("bp hold after occ12", HOLD, 1'b1);
    chk("bp no overflow", OVERFLOW, 1'b0);
    check_model("bp held");

    // Overflow: 17 strobes, 17th dropped, drain order 1..16
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      push(21'(k), 1'b0, 1'b0);
      check_model("ovf fill");
    end
    chk("ovf before drop", OVERFLOW, 1'b0);
    idle(1'b0);
    chk("ovf flag", OVERFLOW, 1'b1);
    check_model("ovf set");
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("ovf drain%0d", k), OUT_DATA, 21'(k));
      idle(1'b1);
      check_model("ovf drain");
    end
    chk("ovf drained empty", OUT_VALID, 1'b0);
    chk("ovf sticky", OVERFLOW, 1'b1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      push(21'h100 + 21'(k), 1'b0, 1'b0);
    end
    idle(1'b0);
    check_model("full reached");
    push(21'h1FFFF, 1'b1, 1'b0);
    idle(1'b1);
    chk("full pp overflow", OVERFLOW, 1'b0);
    chk("full pp head", OUT_DATA, 21'h102);
    chk("full pp evt", EVT_CNT, 16'd1);
    check_model("full pp");
    for (int k = 2; k <= 16; k++) begin
      chk($sformatf("full drain%0d", k), OUT_DATA, 21'h100 + 21'(k));
      idle(1'b1);
    end
    chk("full tail word", OUT_DATA, 21'h1FFFF);
    chk("full tail ee", OUT_EE, 1'b1);
    idle(1'b1);
    chk("full drained", OUT_VALID, 1'b0);
    check_model("full end");

    // Reset mid-stream
    do_reset();
    for (int k = 1; k <= 5; k++) push(21'h200 + 21'(k), 1'b1, 1'b0);
    idle(1'b0);
    chk("mid buffered valid", OUT_VALID, 1'b1);
    chk("mid buffered evt", EVT_CNT, 16'd5);
    step(1'b0, 1'b1, 21'h777, 1'b1, 1'b0, 1'b0);
    chk("mid rst valid", OUT_VALID, 1'b0);
    chk("mid rst evt", EVT_CNT, 16'd0);
    chk("mid rst hold", HOLD, 1'b0);
    push(21'h0BEEF, 1'b0, 1'b0);
    chk("mid first edge valid", OUT_VALID, 1'b0);
    idle(1'b0);
    chk("mid second edge valid", OUT_VALID, 1'b1);
    chk("mid second edge data", OUT_DATA, 21'h0BEEF);
    check_model("mid end");

`ifdef SVT_RX_PARITY_EN
    do_reset();
    step(1'b1, 1'b1, 21'h00001, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("par err flag", PAR_ERR, 1'b1);
    chk("par word valid", OUT_VALID, 1'b1);
    chk("par word data", OUT_DATA, 21'h00001);
    check_model("par");
`endif

    // Randomized traffic with occasional resets and bad parity
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit          r_rstn;
      bit          r_ds;
      bit          r_ee;
      bit          r_rdy;
      bit          r_par;
      logic [20:0] r_data;
      r_rstn = ($urandom_range(0, 199) != 0);
      r_ds   = ($urandom_range(0, 99) < 60);
      r_ee   = ($urandom_range(0, 3) == 0);
      r_rdy  = ($urandom_range(0, 99) < 45);
      r_data = 21'($urandom());
      r_par  = (^r_data) ^ r_ee ^ ($urandom_range(0, 49) == 0);
      step(r_rstn, r_ds, r_data, r_ee, r_rdy, r_par);
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
